channel_tuner: RTL and testbench

Converts the 4-bit channel number selected by the front-panel channel control into the 32-bit NCO frequency word that drives the transmitter, muting the RF output around every retune. It sits between the channel control block and the NCO/modulator and guarantees the carrier never glitches audibly between channels. It also absorbs channel changes that arrive mid-retune, and clamps out-of-range channel numbers.

---
 rtl/channel_tuner.sv | 96 +++++++++
 tb/tb_channel_tuner.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/channel_tuner.sv
// Channel-to-NCO frequency word tuner: mutes the RF output around every retune,
// absorbs channel changes that arrive mid-retune, and clamps out-of-range channels.
module channel_tuner #(
  parameter logic [31:0] BASE         = 32'h1000_0000,
  parameter logic [31:0] STEP         = 32'h0100_0000,
  parameter int          NUM_CHANNELS = 6,
  parameter int          MUTE_CYCLES  = 1024
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  Channel,
  output logic [31:0] Frequency,
  output logic [3:0]  Current,
  output logic        Mute,
  output logic        Ready
);

  localparam logic [3:0]  LAST = 4'(NUM_CHANNELS - 1);
  localparam logic [15:0] CMAX = 16'(MUTE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MUTE_IN, LOAD, SETTLE} state_t;

  state_t      state, state_n;
  logic [15:0] count, count_n;
  logic        mute_n, ready_n, load;
  logic [3:0]  target;
  logic [31:0] freq_n;

  assign target = (Channel > LAST) ? LAST : Channel;
  // 32x32 product truncated to 32 bits equals the 32x4 product truncated
  assign freq_n = BASE + STEP * {28'd0, target};

  always_comb begin
    state_n = state;
    count_n = count;
    mute_n  = Mute;
    ready_n = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: begin
        mute_n  = 1'b0;
        ready_n = 1'b1;
        if (target != Current) begin
          state_n = MUTE_IN;
          mute_n  = 1'b1;
          ready_n = 1'b0;
          count_n = 16'd0;
        end
      end
      MUTE_IN: begin
        count_n = count + 16'd1;
        if (count == CMAX) state_n = LOAD;
      end
      LOAD: begin
        load    = 1'b1;
        count_n = 16'd0;
        state_n = SETTLE;
      end
      SETTLE: begin
        count_n = count + 16'd1;
        if (count == CMAX) begin
          // a change that landed during the settle retunes without a second mute-in
          if (target != Current) begin
            state_n = LOAD;
          end else begin
            state_n = IDLE;
            mute_n  = 1'b0;
            ready_n = 1'b1;
          end
        end
      end
      default: state_n = SETTLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= SETTLE;
      count     <= 16'd0;
      Frequency <= BASE;
      Current   <= 4'd0;
      Mute      <= 1'b1;
      Ready     <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      Mute  <= mute_n;
      Ready <= ready_n;
      if (load) begin
        Current   <= target;
        Frequency <= freq_n;
      end
    end
  end

endmodule

// File: tb/tb_channel_tuner.sv
// Bench for channel_tuner: vector table, hand sequences for retune/reset corners,
// and random channel/reset traffic against an event-schedule reference model.
module tb_channel_tuner;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] STEP = 32'h0100_0000;
  localparam int          NCH  = 6;
  localparam int          M    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ch  = 4'd0;
  logic [31:0] freq, freq6;
  logic [3:0]  cur, cur6;
  logic        mute, mute6, rdy, rdy6;

  always #5 clk = ~clk;

  channel_tuner #(.BASE(BASE), .STEP(STEP), .NUM_CHANNELS(NCH), .MUTE_CYCLES(M)) dut (
    .Clk(clk), .Reset(rst), .Channel(ch),
    .Frequency(freq), .Current(cur), .Mute(mute), .Ready(rdy));

  channel_tuner #(.BASE(BASE), .STEP(32'h4000_0000), .NUM_CHANNELS(NCH), .MUTE_CYCLES(M)) dut6 (
    .Clk(clk), .Reset(rst), .Channel(ch),
    .Frequency(freq6), .Current(cur6), .Mute(mute6), .Ready(rdy6));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [31:0] f, input logic [3:0] c,
                         input logic m, input logic r);
    chk({name, ".freq"},  freq,        f);
    chk({name, ".cur"},   32'(cur),    32'(c));
    chk({name, ".mute"},  32'(mute),   32'(m));
    chk({name, ".ready"}, 32'(rdy),    32'(r));
  endtask

  function automatic logic [3:0] clampc(input logic [3:0] c);
    return (int'(c) >= NCH) ? 4'(NCH - 1) : c;
  endfunction

  function automatic logic [31:0] fword(input logic [31:0] step, input logic [3:0] t);
    longint v;
    v = longint'(BASE) + longint'(step) * longint'(t);
    return v[31:0];
  endfunction

  // Reference model: tracks absolute edge numbers at which the next load and the
  // next end-of-settle decision fall due, rather than any state/counter encoding.
  int          n;
  int          load_e;
  int          dec_e;
  logic [3:0]  mcur;
  logic [31:0] mfreq;
  logic        mmute;

  always @(posedge clk) begin : model
    logic [3:0] t;
    t = clampc(ch);
    if (rst) begin
      n = 0; load_e = -1; dec_e = M; mcur = 4'd0; mfreq = BASE; mmute = 1'b1;
    end else begin
      n++;
      if (!mmute) begin
        if (t != mcur) begin
          mmute  = 1'b1;
          load_e = n + M + 1;
        end
      end else if (n == load_e) begin
        mcur  = t;
        mfreq = fword(STEP, t);
        dec_e = n + M;
      end else if (n == dec_e) begin
        if (t != mcur) load_e = n + 1;
        else mmute = 1'b0;
      end
    end
  end

  typedef struct {
    logic [3:0]  ch;
    int          adv;
    logic [31:0] f;
    logic [3:0]  c;
    logic        m;
    logic        r;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // each entry: drive channel, advance adv edges, then compare
    tbl[0]  = '{4'd3, 1,  32'h1000_0000, 4'd0, 1'b1, 1'b0};
    tbl[1]  = '{4'd3, 4,  32'h1000_0000, 4'd0, 1'b1, 1'b0};
    tbl[2]  = '{4'd3, 1,  32'h1300_0000, 4'd3, 1'b1, 1'b0};
    tbl[3]  = '{4'd3, 3,  32'h1300_0000, 4'd3, 1'b1, 1'b0};
    tbl[4]  = '{4'd3, 1,  32'h1300_0000, 4'd3, 1'b0, 1'b1};
    tbl[5]  = '{4'd9, 1,  32'h1300_0000, 4'd3, 1'b1, 1'b0};
    tbl[6]  = '{4'd9, 5,  32'h1500_0000, 4'd5, 1'b1, 1'b0};
    tbl[7]  = '{4'd9, 4,  32'h1500_0000, 4'd5, 1'b0, 1'b1};
    tbl[8]  = '{4'd9, 20, 32'h1500_0000, 4'd5, 1'b0, 1'b1};
    tbl[9]  = '{4'd5, 3,  32'h1500_0000, 4'd5, 1'b0, 1'b1};
    tbl[10] = '{4'd0, 1,  32'h1500_0000, 4'd5, 1'b1, 1'b0};
    tbl[11] = '{4'd0, 8,  32'h1000_0000, 4'd0, 1'b1, 1'b0};
    tbl[12] = '{4'd0, 1,  32'h1000_0000, 4'd0, 1'b0, 1'b1};

    // reset hold and boot settle on channel 0
    rst = 1'b1; ch = 4'd0;
    repeat (3) @(negedge clk);
    chk_all("reset", BASE, 4'd0, 1'b1, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= M; k++) begin
      @(negedge clk);
      chk_all($sformatf("boot%0d", k), BASE, 4'd0, k < M, k >= M);
    end

    for (int i = 0; i < 13; i++) begin
      ch = tbl[i].ch;
      repeat (tbl[i].adv) @(negedge clk);
      chk_all($sformatf("vec%0d", i), tbl[i].f, tbl[i].c, tbl[i].m, tbl[i].r);
    end

    // change to 5 two cycles into settle: direct reload, mute held throughout
    ch = 4'd3;
    for (int d = 0; d <= 15; d++) begin
      @(negedge clk);
      chk_all($sformatf("retune_d%0d", d),
              (d < 5) ? BASE : (d < 10) ? 32'h1300_0000 : 32'h1500_0000,
              (d < 5) ? 4'd0 : (d < 10) ? 4'd3 : 4'd5,
              d < 14, d >= 14);
      if (d == 7) ch = 4'd5;
    end

    // asynchronous reset in the middle of mute-in, then recovery to channel 1
    ch = 4'd1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1 chk_all("async_rst", BASE, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk_all($sformatf("recover%0d", k),
              (k < 5) ? BASE : 32'h1100_0000, (k < 5) ? 4'd0 : 4'd1, k < 9, k >= 9);
    end

    // random channel changes and occasional resets against the model
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      chk_all("rand", mfreq, mcur, mmute, !mmute);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      else if ($urandom_range(0, 7) == 0) ch = 4'($urandom_range(0, 15));
    end

    // wrap-around: 0x1000_0000 + 5*0x4000_0000 mod 2^32
    ch = 4'd5; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("wrap.freq",  freq6,       32'h5000_0000);
    chk("wrap.cur",   32'(cur6),   32'd5);
    chk("wrap.mute",  32'(mute6),  32'd0);
    chk("wrap.ready", 32'(rdy6),   32'd1);
    chk("nowrap.freq", freq,       32'h1500_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
